amux_sel_sequencer: RTL and testbench

Parametrised successor to the analog-mux decoder. Turns a binary channel request into a registered one-hot switch-enable bus with break-before-make (BBM) sequencing: all switches open for a programmable dead time, then the new channel closes, then a settle interval passes before the result is flagged. It sits between the digital control/register logic and the transmission-gate array of any N-channel analog mux.

---
 rtl/amux_pkg.sv | 23 ++
 rtl/amux_onehot_dec.sv | 19 +
 rtl/amux_sel_sequencer.sv | 153 +++++++++++++++
 tb/tb_amux_sel_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/amux_pkg.sv
// Shared types and helpers for the analog-mux break-before-make sequencer.
package amux_pkg;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_CH    = 256;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2,
    ON     = 2'd3
  } state_e;

  // Widest one-hot vector; callers cast it down to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_CH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/amux_onehot_dec.sv
// Parametrised binary-to-one-hot switch decoder with enable and range check.
module amux_onehot_dec #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned N_CH  = 32
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_CH-1:0]  oh_c,
  output logic             in_range_c
);
  import amux_pkg::*;

  always_comb begin
    in_range_c = (32'(sel) < N_CH);
    oh_c       = '0;
    if (en && in_range_c) oh_c = N_CH'(onehot(MAX_SEL_W'(sel)));
  end

endmodule

// File: rtl/amux_sel_sequencer.sv
// Break-before-make sequencer: registered one-hot switch enables with a
// programmable all-open dead time and a post-make settle interval.
module amux_sel_sequencer #(
  parameter int unsigned SEL_W         = 5,
  parameter int unsigned N_CH          = 32,
  parameter int unsigned BBM_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             ready,
  output logic [N_CH-1:0]  y,
  output logic [N_CH-1:0]  y_b,
  output logic             busy,
  output logic             settled,
  output logic             done,
  output logic             err
);
  import amux_pkg::*;

  localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic               pend_en_q, pend_en_d;
  logic [N_CH-1:0]    pend_oh_q, pend_oh_d;
  logic [N_CH-1:0]    y_q, y_d, y_b_q, y_b_d;
  logic               ready_q, ready_d, busy_q, busy_d, settled_q, settled_d;
  logic               done_q, done_d, err_q, err_d;

  logic [N_CH-1:0]    oh_c;
  logic               in_range_c, accept_c, same_ch_c;

  amux_onehot_dec #(.SEL_W(SEL_W), .N_CH(N_CH)) u_dec (
    .sel        (sel),
    .en         (en),
    .oh_c       (oh_c),
    .in_range_c (in_range_c)
  );

  assign accept_c  = req && ready_q;
  assign same_ch_c = (state_q == ON) && en && (sel == cur_sel_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OFF;
    else     state_q <= state_d;
  end

  // Next-state, dead-time/settle counter and pending request capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_sel_d = pend_sel_q;
    pend_en_d  = pend_en_q;
    pend_oh_d  = pend_oh_q;
    case (state_q)
      OFF, ON: begin
        if (accept_c && in_range_c && !same_ch_c) begin
          state_d    = BREAK;
          cnt_d      = BBM_LOAD;
          pend_sel_d = sel;
          pend_en_d  = en;
          pend_oh_d  = oh_c;
        end
      end
      BREAK: begin
        if (cnt_q != '0)              cnt_d   = cnt_q - 1'b1;
        else if (!pend_en_q)          state_d = OFF;
        else if (SETTLE_CYCLES == 0)  state_d = ON;
        else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
        else             state_d = ON;
      end
      default: state_d = OFF;
    endcase
  end

  // Output next values; switches only change on BREAK entry (all open) or exit (make)
  always_comb begin
    y_d       = y_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    err_d     = accept_c && !in_range_c;
    ready_d   = (state_d == OFF) || (state_d == ON);
    busy_d    = (state_d == BREAK) || (state_d == SETTLE);
    settled_d = (state_d == ON);
    if (accept_c && in_range_c && same_ch_c) done_d = 1'b1;
    if (state_d == BREAK) y_d = '0;
    if (state_q == BREAK && state_d != BREAK) begin
      y_d = pend_oh_q;
      if (pend_en_q) cur_sel_d = pend_sel_q;
      if (state_d != SETTLE) done_d = 1'b1;
    end
    if (state_q == SETTLE && state_d == ON) done_d = 1'b1;
    y_b_d = ~y_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_sel_q  <= '0;
      pend_sel_q <= '0;
      pend_en_q  <= 1'b0;
      pend_oh_q  <= '0;
      y_q        <= '0;
      y_b_q      <= '1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      settled_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      pend_en_q  <= pend_en_d;
      pend_oh_q  <= pend_oh_d;
      y_q        <= y_d;
      y_b_q      <= y_b_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      settled_q  <= settled_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign y       = y_q;
  assign y_b     = y_b_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign settled = settled_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_amux_sel_sequencer.sv
// Bench for amux_sel_sequencer: two configurations checked cycle by cycle
// against a timeline model (dead time, settle time, done/err pulses).
module tb_amux_sel_sequencer;

  localparam int unsigned SEL_W = 5;
  localparam int unsigned NA = 32, BA = 2, SA = 8;
  localparam int unsigned NB = 20, BB = 1, SB = 0;

  logic clk = 1'b0;
  logic rst;

  logic             req_a, en_a, ready_a, busy_a, settled_a, done_a, err_a;
  logic [SEL_W-1:0] sel_a;
  logic [NA-1:0]    y_a, y_b_a;

  logic             req_b, en_b, ready_b, busy_b, settled_b, done_b, err_b;
  logic [SEL_W-1:0] sel_b;
  logic [NB-1:0]    y_bb, y_b_bb;

  int n_checks = 0;
  int n_fail   = 0;
  bit on_m [2];
  int ch_m [2];

  always #5 clk = ~clk;

  amux_sel_sequencer #(.SEL_W(SEL_W), .N_CH(NA), .BBM_CYCLES(BA), .SETTLE_CYCLES(SA)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .sel(sel_a), .en(en_a), .ready(ready_a),
    .y(y_a), .y_b(y_b_a), .busy(busy_a), .settled(settled_a), .done(done_a), .err(err_a)
  );

  amux_sel_sequencer #(.SEL_W(SEL_W), .N_CH(NB), .BBM_CYCLES(BB), .SETTLE_CYCLES(SB)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .sel(sel_b), .en(en_b), .ready(ready_b),
    .y(y_bb), .y_b(y_b_bb), .busy(busy_b), .settled(settled_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic r, input logic [SEL_W-1:0] s, input logic e);
    if (w == 0) begin req_a = r; sel_a = s; en_a = e; end
    else        begin req_b = r; sel_b = s; en_b = e; end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input int w, input string tag, input int k, input logic [31:0] y_e,
                           input logic rdy_e, input logic bsy_e, input logic stl_e,
                           input logic dn_e, input logic er_e);
    logic [31:0] yo, ybo, mask;
    logic        rdy, bsy, stl, dn, er;
    string       p;
    if (w == 0) begin
      yo = y_a; ybo = y_b_a; rdy = ready_a; bsy = busy_a; stl = settled_a; dn = done_a; er = err_a;
      mask = 32'hFFFF_FFFF;
    end else begin
      yo = 32'(y_bb); ybo = 32'(y_b_bb); rdy = ready_b; bsy = busy_b; stl = settled_b;
      dn = done_b; er = err_b;
      mask = (32'd1 << NB) - 32'd1;
    end
    p = $sformatf("%s_%s_k%0d", (w == 0) ? "a" : "b", tag, k);
    check({p, "_y"},       yo,  y_e);
    check({p, "_y_b"},     ybo, ~y_e & mask);
    check({p, "_ready"},   32'(rdy), 32'(rdy_e));
    check({p, "_busy"},    32'(bsy), 32'(bsy_e));
    check({p, "_settled"}, 32'(stl), 32'(stl_e));
    check({p, "_done"},    32'(dn),  32'(dn_e));
    check({p, "_err"},     32'(er),  32'(er_e));
  endtask

  // One request on instance w; expected trace derived from the timing rules.
  task automatic do_req(input int w, input logic [SEL_W-1:0] s, input logic e, input string tag);
    int          n, b, st, lat;
    logic [31:0] y_prev, y_new, y_e;
    bit          in_rng, same, busy_e;
    n  = (w == 0) ? NA : NB;
    b  = (w == 0) ? BA : BB;
    st = (w == 0) ? SA : SB;
    y_prev = on_m[w] ? (32'd1 << ch_m[w]) : 32'd0;
    in_rng = int'(s) < n;
    same   = in_rng && e && on_m[w] && (int'(s) == ch_m[w]);
    drive(w, 1'b1, s, e);
    step();
    if (!in_rng || same) begin
      drive(w, 1'b0, '0, 1'b0);
      check_all(w, tag, 1, y_prev, 1'b1, 1'b0, on_m[w], same, !in_rng);
      step();
      check_all(w, tag, 2, y_prev, 1'b1, 1'b0, on_m[w], 1'b0, 1'b0);
    end else begin
      lat   = e ? (1 + b + st) : (1 + b);
      y_new = e ? (32'd1 << s) : 32'd0;
      for (int k = 1; k <= lat + 1; k++) begin
        busy_e = (k < lat);
        y_e    = (e && k > b) ? y_new : 32'd0;
        check_all(w, tag, k, y_e, !busy_e, busy_e, e && (k >= lat), k == lat, 1'b0);
        // Requests while busy must be ignored
        if (busy_e) drive(w, 1'($urandom), SEL_W'($urandom), 1'($urandom));
        else        drive(w, 1'b0, '0, 1'b0);
        step();
      end
      on_m[w] = e;
      if (e) ch_m[w] = int'(s);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    on_m[0] = 1'b0; on_m[1] = 1'b0;
    ch_m[0] = 0;    ch_m[1] = 0;
    repeat (2) @(negedge clk);
    check_all(0, "rst", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all(1, "rst", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    do_req(0, 5'd5,  1'b1, "conn5");
    do_req(0, 5'd31, 1'b1, "sw31");
    do_req(0, 5'd31, 1'b1, "same31");
    do_req(0, 5'd31, 1'b0, "dis");
    do_req(1, 5'd25, 1'b1, "rng25");
    do_req(1, 5'd7,  1'b1, "b7");
    do_req(1, 5'd7,  1'b1, "b7same");
    do_req(1, 5'd19, 1'b1, "b19");
    do_req(1, 5'd20, 1'b0, "rng20");

    // Asynchronous reset in the middle of a settle interval
    drive(0, 1'b1, 5'd9, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b0);
    repeat (4) step();
    check_all(0, "presettle", 5, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all(0, "arst", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all(1, "arst", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    on_m[0] = 1'b0; on_m[1] = 1'b0;
    ch_m[0] = 0;    ch_m[1] = 0;
    @(negedge clk);
    check_all(0, "arst_hold", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    do_req(0, 5'd3, 1'b1, "post_rst3");

    for (int i = 0; i < 40; i++) begin
      int               w;
      logic [SEL_W-1:0] s;
      logic             e;
      w = int'($urandom_range(0, 1));
      s = SEL_W'($urandom);
      if ($urandom_range(0, 3) == 0 && on_m[w]) s = SEL_W'(ch_m[w]);
      e = ($urandom_range(0, 3) != 0);
      do_req(w, s, e, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
